// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_fifo_ctrl
//  Purpose  : FIFO of DEPTH+2 words built from a single-port synchronous SRAM
//             (DEPTH words) plus a 2-entry output buffer (obuf). Reads into
//             the obuf take priority over writes; one SRAM access per cycle.
//  Ports    : clk, rstn (async, active-low)
//             in_valid/in_ready/in_data     - push side (valid/ready)
//             out_valid/out_ready/out_data  - pop side (valid/ready)
//             sram_cs/sram_we/sram_ad/sram_wd/sram_rd - SRAM port
//             level (only with SRAM_FIFO_LEVEL_EN) - words held in total
//  Options  : define SRAM_FIFO_LEVEL_EN to add the level output port.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sram_cs,
    output logic             sram_we,
    output logic [AW-1:0]    sram_ad,
    output logic [WIDTH-1:0] sram_wd,
    input  logic [WIDTH-1:0] sram_rd
`ifdef SRAM_FIFO_LEVEL_EN
    ,
    output logic [AW+1:0]    level
`endif
);

    localparam logic [AW:0]   FULL_CNT = DEPTH;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [1:0]    OB_ONE   = 2'd1;
    localparam logic [1:0]    OB_TWO   = 2'd2;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      sram_cnt;
    logic             rd_inflight;
    logic [1:0]       ob_cnt;
    logic             ob_head;
    logic [WIDTH-1:0] ob0;
    logic [WIDTH-1:0] ob1;

    logic             rd_issue;
    logic             push;
    logic             pop;
    logic             ob_tail;

    // A read is only launched when the obuf is guaranteed a free slot for
    // its data, counting a read already in flight. Gating with rstn keeps
    // every SRAM strobe low while reset is held.
    assign rd_issue = rstn && (sram_cnt != '0) && ((ob_cnt + {1'b0, rd_inflight}) < OB_TWO);

    // Depends only on registered state and rstn: no path from in_valid or
    // out_ready.
    assign in_ready = rstn && (sram_cnt != FULL_CNT) && !rd_issue;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        sram_cs = rd_issue || push;
        sram_we = push;
        sram_ad = '0;
        sram_wd = '0;
        if (rd_issue) begin
            sram_ad = rd_ptr;
        end else if (push) begin
            sram_ad = wr_ptr;
            sram_wd = in_data;
        end
    end

    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob_head ? ob1 : ob0;

    // Next free obuf slot. A capture never meets a full obuf because a read
    // is issued only while occupancy plus in-flight is below two.
    assign ob_tail = ob_head ^ ob_cnt[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
            ob_cnt      <= 2'd0;
            ob_head     <= 1'b0;
            ob0         <= '0;
            ob1         <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, rd_issue})
                2'b10:   sram_cnt <= sram_cnt + CNT_ONE;
                2'b01:   sram_cnt <= sram_cnt - CNT_ONE;
                default: sram_cnt <= sram_cnt;
            endcase

            // A reset clears this flag, so data of an aborted read is never
            // captured.
            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                if (ob_tail) begin
                    ob1 <= sram_rd;
                end else begin
                    ob0 <= sram_rd;
                end
            end

            case ({rd_inflight, pop})
                2'b10:   ob_cnt <= ob_cnt + OB_ONE;
                2'b01:   ob_cnt <= ob_cnt - OB_ONE;
                default: ob_cnt <= ob_cnt;
            endcase
            if (pop) begin
                ob_head <= ~ob_head;
            end
        end
    end

`ifdef SRAM_FIFO_LEVEL_EN
    assign level = {1'b0, sram_cnt}
                 + {{AW{1'b0}}, ob_cnt}
                 + {{(AW+1){1'b0}}, rd_inflight};
`endif

endmodule
`default_nettype wire
